// File: rtl/tdc_pkg.sv
// ============================================================================
// Package : tdc_pkg
// Desc    : Shared constants and helpers for the TDC timestamping back end.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package tdc_pkg;

  localparam int DROP_W = 8;

  typedef enum logic [0:0] {
    POL_FALL = 1'b0,
    POL_RISE = 1'b1
  } edge_pol_e;

  // Entry layout is {coarse, fine, pol}.
  function automatic int fifo_entry_w(input int coarse_w, input int fine_w);
    return coarse_w + fine_w + 1;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tdc_event_fifo.sv
// ============================================================================
// Module : tdc_event_fifo
// Desc   : Synchronous circular FIFO with a registered head (no write bypass).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdc_event_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  localparam int c_ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W  = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [c_ADDR_W-1:0] r_wr_ptr;
  logic [c_ADDR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic                r_valid;
  logic [WIDTH-1:0]    r_data;

  logic                w_full;
  logic                w_pop;
  logic                w_wr;
  logic [c_ADDR_W-1:0] w_rd_next;
  logic [c_CNT_W-1:0]  w_count_after_pop;

  assign w_full            = (r_count == c_CNT_W'(DEPTH));
  assign w_pop             = i_pop & r_valid;
  assign w_wr              = i_push & (~w_full | w_pop);
  assign w_rd_next         = r_rd_ptr + c_ADDR_W'(w_pop);
  assign w_count_after_pop = r_count - c_CNT_W'(w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Head reloads from pre-edge storage only, so a push into an empty FIFO
  // becomes visible one cycle after it is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + c_ADDR_W'(w_wr);
      r_rd_ptr <= w_rd_next;
      r_count  <= r_count + c_CNT_W'(w_wr) - c_CNT_W'(w_pop);
      r_valid  <= (w_count_after_pop != '0);
      if (w_count_after_pop != '0) begin
        r_data <= r_mem[w_rd_next];
      end
    end
  end

  assign o_full  = w_full;
  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/tdc_timestamper.sv
// ============================================================================
// Module : tdc_timestamper
// Desc   : Registers TDC tap samples, bubble-filters and popcounts them, tags
//          edges with a coarse count and queues them on a valid/ready stream.
// Config : define TDC_FALLING_EDGE_EN to also timestamp falling edges.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdc_timestamper
  import tdc_pkg::*;
#(
  parameter int TAPS     = 100,
  parameter int COARSE_W = 16,
  parameter int DEPTH    = 16
) (
  input  logic                      clk,
  input  logic                      RESET,
  input  logic [TAPS-1:0]           tap,
  input  logic                      clear_ovf,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [COARSE_W-1:0]       out_coarse,
  output logic [$clog2(TAPS+1)-1:0] out_fine,
  output logic                      out_pol,
  output logic                      overflow,
  output logic [DROP_W-1:0]         drop_cnt
);

  localparam int FINE_W    = $clog2(TAPS + 1);
  localparam int c_ENTRY_W = fifo_entry_w(COARSE_W, FINE_W);

  // S0: sample and coarse tag
  logic [COARSE_W-1:0] r_coarse;
  logic [TAPS-1:0]     r_s0;
  logic [COARSE_W-1:0] r_c0;
  logic                r_s0_vld;

  // S1: filtered sample and event flag
  logic                r_h;
  logic                r_armed;
  logic [TAPS-1:0]     r_f1;
  logic [COARSE_W-1:0] r_c1;
  logic                r_ev1;

  // S2: encoded event
  logic [FINE_W-1:0]   r_fine2;
  logic [COARSE_W-1:0] r_c2;
  logic                r_ev2;

  logic                r_overflow;
  logic [DROP_W-1:0]   r_drop_cnt;

  logic [TAPS-1:0]     w_f;
  logic [FINE_W-1:0]   w_pc;
  logic [FINE_W-1:0]   w_fine;
  logic                w_rise;
  logic                w_fall;
  logic                w_pol2;
  logic                w_full;
  logic                w_pop;
  logic                w_drop;
  logic [c_ENTRY_W-1:0] w_push_data;
  logic [c_ENTRY_W-1:0] w_head;

  // Chain ends replicate the edge tap so a lone boundary bit is not eaten.
  for (genvar gi = 0; gi < TAPS; gi++) begin : g_filter
    localparam int c_LO = (gi == 0) ? 0 : gi - 1;
    localparam int c_HI = (gi == TAPS - 1) ? TAPS - 1 : gi + 1;
    assign w_f[gi] = maj3(r_s0[c_LO], r_s0[gi], r_s0[c_HI]);
  end

  assign w_rise = r_armed & r_s0[0] & ~r_h;

  always_comb begin
    w_pc = '0;
    for (int i = 0; i < TAPS; i++) begin
      w_pc = w_pc + FINE_W'(r_f1[i]);
    end
  end

`ifdef TDC_FALLING_EDGE_EN
  logic r_pol1;
  logic r_pol2;

  assign w_fall = r_armed & ~r_s0[0] & r_h;
  // A falling edge leaves zeros behind it, so the distance is the zero count.
  assign w_fine = r_pol1 ? w_pc : (FINE_W'(TAPS) - w_pc);
  assign w_pol2 = r_pol2;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_pol1 <= 1'b0;
      r_pol2 <= 1'b0;
    end else begin
      r_pol1 <= w_rise;
      r_pol2 <= r_pol1;
    end
  end
`else
  assign w_fall = 1'b0;
  assign w_fine = w_pc;
  assign w_pol2 = POL_RISE;
`endif

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_coarse <= '0;
      r_s0     <= '0;
      r_c0     <= '0;
      r_s0_vld <= 1'b0;
    end else begin
      r_coarse <= r_coarse + COARSE_W'(1);
      r_s0     <= tap;
      r_c0     <= r_coarse;
      r_s0_vld <= 1'b1;
    end
  end

  // The first sample after reset only seeds the history bit.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_h     <= 1'b0;
      r_armed <= 1'b0;
      r_f1    <= '0;
      r_c1    <= '0;
      r_ev1   <= 1'b0;
    end else begin
      if (r_s0_vld) begin
        r_h     <= r_s0[0];
        r_armed <= 1'b1;
      end
      r_f1  <= w_f;
      r_c1  <= r_c0;
      r_ev1 <= w_rise | w_fall;
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_fine2 <= '0;
      r_c2    <= '0;
      r_ev2   <= 1'b0;
    end else begin
      r_fine2 <= w_fine;
      r_c2    <= r_c1;
      r_ev2   <= r_ev1;
    end
  end

  assign w_pop       = out_valid & out_ready;
  assign w_drop      = r_ev2 & w_full & ~w_pop;
  assign w_push_data = {r_c2, r_fine2, w_pol2};

  // A drop coinciding with clear_ovf restarts the count at one.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clear_ovf) begin
        r_drop_cnt <= DROP_W'(1);
      end else if (r_drop_cnt != {DROP_W{1'b1}}) begin
        r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      end
    end else if (clear_ovf) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  tdc_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (c_ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (RESET),
    .i_push  (r_ev2),
    .i_data  (w_push_data),
    .o_full  (w_full),
    .i_pop   (out_ready),
    .o_valid (out_valid),
    .o_data  (w_head)
  );

  assign {out_coarse, out_fine, out_pol} = w_head;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_tdc_timestamper.sv
// ============================================================================
// Module : tb_tdc_timestamper
// Desc   : Self-checking bench for tdc_timestamper (TAPS=16, DEPTH=4, COARSE_W=8).
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tdc_timestamper;

  localparam int TAPS     = 16;
  localparam int COARSE_W = 8;
  localparam int DEPTH    = 4;
  localparam int FINE_W   = 5;

  logic                clk = 1'b0;
  logic                RESET;
  logic [TAPS-1:0]     tap;
  logic                clear_ovf;
  logic                out_valid;
  logic                out_ready;
  logic [COARSE_W-1:0] out_coarse;
  logic [FINE_W-1:0]   out_fine;
  logic                out_pol;
  logic                overflow;
  logic [7:0]          drop_cnt;

  tdc_timestamper #(
    .TAPS     (TAPS),
    .COARSE_W (COARSE_W),
    .DEPTH    (DEPTH)
  ) dut (
    .clk        (clk),
    .RESET      (RESET),
    .tap        (tap),
    .clear_ovf  (clear_ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_coarse (out_coarse),
    .out_fine   (out_fine),
    .out_pol    (out_pol),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [COARSE_W-1:0] coarse;
    logic [FINE_W-1:0]   fine;
    logic                pol;
  } ev_t;

  typedef struct {
    logic [TAPS-1:0] tap;
    int              fine;
  } vec_t;

  ev_t             sb[$];
  ev_t             m_e;
  vec_t            vecs[6];
  int              n_cmp = 0;
  int              n_err = 0;
  logic [7:0]      tb_coarse;
  logic            tb_h;
  logic            tb_armed;
  logic            hold_mode;
  int              exp_drops;
  logic [TAPS-1:0] cur_tap;

  // Coarse count the DUT should be showing: zero at reset, +1 per clk.
  always @(posedge clk or posedge RESET) begin
    if (RESET) tb_coarse <= 8'd0;
    else       tb_coarse <= tb_coarse + 8'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input ev_t e);
    if (hold_mode && sb.size() >= DEPTH) exp_drops++;
    else sb.push_back(e);
  endtask

  // Drive one sample and register the event it should produce.
  task automatic cyc(input logic [TAPS-1:0] v, input int fine);
    ev_t e;
    tap     = v;
    cur_tap = v;
    if (tb_armed && v[0] && !tb_h) begin
      e.coarse = tb_coarse;
      e.fine   = FINE_W'(fine);
      e.pol    = 1'b1;
      push_exp(e);
    end
`ifdef TDC_FALLING_EDGE_EN
    else if (tb_armed && !v[0] && tb_h) begin
      e.coarse = tb_coarse;
      e.fine   = (fine < 0) ? FINE_W'(TAPS) : FINE_W'(fine);
      e.pol    = 1'b0;
      push_exp(e);
    end
`endif
    tb_h     = v[0];
    tb_armed = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      cyc(cur_tap, -1);
      k++;
    end
    check("drain_complete", sb.size(), 0);
    repeat (6) cyc(cur_tap, -1);
  endtask

  task automatic mid_reset();
    RESET = 1'b1;
    sb.delete();
    tb_armed = 1'b0;
    tb_h     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    RESET = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!RESET && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_event: got coarse=%0d fine=%0d pol=%0d expected none",
                 out_coarse, out_fine, out_pol);
      end else begin
        m_e = sb.pop_front();
        check("out_coarse", out_coarse, m_e.coarse);
        check("out_fine", out_fine, m_e.fine);
        check("out_pol", out_pol, m_e.pol);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h003F, 6};
    vecs[1] = '{16'h00BF, 7};
    vecs[2] = '{16'h0047, 3};
    vecs[3] = '{16'hFFFF, 16};
    vecs[4] = '{16'h0001, 1};
    vecs[5] = '{16'h0003, 2};

    RESET     = 1'b1;
    tap       = '0;
    cur_tap   = '0;
    clear_ovf = 1'b0;
    out_ready = 1'b0;
    tb_h      = 1'b0;
    tb_armed  = 1'b0;
    hold_mode = 1'b0;
    exp_drops = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_out_coarse", out_coarse, 0);
    check("rst_out_fine", out_fine, 0);
    check("rst_out_pol", out_pol, 0);
    RESET = 1'b0;

    // Priming and 4-cycle latency
    while (tb_coarse != 8'd10) cyc(16'h0000, -1);
    cyc(16'h003F, 6);
    repeat (3) cyc(16'hFFFF, -1);
    check("latency_early", out_valid, 0);
    cyc(16'hFFFF, -1);
    check("latency_valid", out_valid, 1);
    out_ready = 1'b1;
    drain(50);

    // Bubble filter / popcount table
    for (int i = 0; i < 6; i++) begin
      cyc(16'h0000, -1);
      cyc(vecs[i].tap, vecs[i].fine);
      cyc(vecs[i].tap, -1);
    end
    drain(100);

    // Overflow with a stalled consumer
    out_ready = 1'b0;
    hold_mode = 1'b1;
    exp_drops = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(16'h0000, -1);
      cyc(16'h000F, 4);
    end
    repeat (5) cyc(16'h000F, -1);
    check("ovf_valid", out_valid, 1);
    check("ovf_flag", overflow, 1);
    check("ovf_drop_cnt", drop_cnt, 32'(exp_drops));

    // Drop landing on the clear_ovf cycle
    cyc(16'h0000, -1);
    cyc(16'h000F, 4);
    cyc(16'h000F, -1);
    cyc(16'h000F, -1);
    clear_ovf = 1'b1;
    cyc(16'h000F, -1);
    clear_ovf = 1'b0;
    check("drop_wins_flag", overflow, 1);
    check("drop_wins_cnt", drop_cnt, 1);
    clear_ovf = 1'b1;
    cyc(16'h000F, -1);
    clear_ovf = 1'b0;
    check("clear_flag", overflow, 0);
    check("clear_cnt", drop_cnt, 0);
    out_ready = 1'b1;
    hold_mode = 1'b0;
    drain(100);
    check("post_drain_ovf", overflow, 0);

    // Coarse wrap: events at 255 then 0
    while (tb_coarse != 8'd255) cyc(16'h0000, -1);
    cyc(16'h003F, 6);
    cyc(16'h0000, -1);
    while (tb_coarse != 8'd0) cyc(16'h0000, -1);
    cyc(16'h003F, 6);
    cyc(16'h003F, -1);
    drain(50);

    // Reset mid-stream with the chain saturated
    cyc(16'h0000, -1);
    cyc(16'h003F, 6);
    tap     = 16'hFFFF;
    cur_tap = 16'hFFFF;
    mid_reset();
    repeat (8) cyc(16'hFFFF, -1);
    check("reprime_no_event", out_valid, 0);
    cyc(16'h0000, -1);
    cyc(16'hFFFF, 16);
    cyc(16'hFFFF, -1);
    drain(50);

    // Falling edge
    cyc(16'hFFFF, -1);
    cyc(16'hFFF0, 4);
    cyc(16'hFFF0, -1);
    drain(50);
`ifndef TDC_FALLING_EDGE_EN
    check("no_falling_event", out_valid, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tdc_timestamper.md
Name: tdc_timestamper

Overview:
- Next-generation TDC back end that turns the raw carry-chain tap vector, sampled once per clk, into timestamped events.
- Each sample is registered, bubble-filtered and popcount-encoded into a fine code, then combined with a free-running coarse counter.
- Events are buffered in a FIFO and drained over a valid/ready stream, for example by a UART formatter.
- Sits between the TAPS-wide chain sampling flops (instantiated in the TDC top) and the readout logic.

Parameters:
- TAPS, 100: number of chain taps sampled per clk; must be ≥ 4.
- COARSE_W, 16: width of the coarse cycle counter.
- DEPTH, 16: FIFO entries; must be a power of two, ≥ 2.
- FINE_W, $clog2(TAPS+1): derived localparam, not overridable.

Ports:
- clk  in  1  sample/system clock.
- RESET  in  1  asynchronous, active-high reset.
- tap  in  TAPS  raw chain sample; tap[0] is nearest the input pin.
- clear_ovf  in  1  one-cycle pulse; clears the overflow flag and drop count.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head when out_valid is also high.
- out_coarse  out  COARSE_W  coarse count of the head event.
- out_fine  out  FINE_W  fine code of the head event, in taps.
- out_pol  out  1  edge polarity of the head event; 1 = rising.
- overflow  out  1  sticky: at least one event was dropped.
- drop_cnt  out  8  count of dropped events; saturates at 255.

Behaviour:
- Reset: clk and RESET are the only clock and reset. RESET is asynchronous and active-high, and clears every register. After reset, out_valid=0, overflow=0, drop_cnt=0, out_coarse/out_fine/out_pol=0, the coarse counter=0 and the FIFO is empty.
- S0 (cycle n): register tap into s0 and capture the coarse counter value as c0. The coarse counter increments every clk and wraps modulo 2^COARSE_W.
- Priming: the first S0 sample after reset only loads the history bit h=s0[0]. No event is produced from it. An armed flag is set after this sample.
- S1 bubble filter: f[i]=majority(s0[i-1],s0[i],s0[i+1]), with s0[-1]=s0[0] and s0[TAPS]=s0[TAPS-1].
- S1 rising event: armed && s0[0]=1 && h=0.
- S1 history: h<=s0[0] on every cycle.
- S2 encode (rising): fine = popcount(f), range 0..TAPS.
- Event pulse: f and the event flag are registered through S1 and S2. The FIFO push occurs on cycle n+3 with {c0, fine, pol}.
- Latency: tap sample edge to out_valid rising, when the FIFO was empty, is 4 clks.
- An all-ones sample with h=0 is reported with fine=TAPS; this means the edge outran the chain.
- An edge spanning several samples is reported exactly once, by the sample where tap[0] first reads 1.
- FIFO push: the push is accepted if not full, or if a pop occurs in the same cycle.
- FIFO overflow: otherwise the event is dropped, overflow<=1 and drop_cnt increments (saturating at 255).
- FIFO pop: occurs on out_valid && out_ready.
- Stream outputs: they are driven from the head register. They are held stable while out_valid && !out_ready.
- Push and pop on empty: no bypass. The pushed event becomes valid on the next cycle.
- clear_ovf: clears overflow and drop_cnt. If a drop occurs in the same cycle, the drop wins: overflow=1 and drop_cnt=1.
- RESET mid-stream: the FIFO contents are discarded, and the next sample re-primes the history.

Optional Feature:
- Macro TDC_FALLING_EDGE_EN.
- When defined: a falling event is armed && s0[0]=0 && h=1, with fine = TAPS − popcount(f) and out_pol=0. Rising events are unchanged.
- When undefined: falling transitions produce no event, out_pol is tied to 1, and the popcount-inversion logic is not built.

Decomposition:
- Package tdc_pkg holds DROP_W=8, the FIFO entry width helper function (COARSE_W+FINE_W+1), and the majority-3 function.
- One sub-module, tdc_event_fifo: a parametrised synchronous FIFO with DEPTH/WIDTH parameters, push/full and pop/empty, and registered head outputs.
- Bubble filter and popcount remain inline.

Test Plan (TAPS=16, DEPTH=4, COARSE_W=8):
- Rising edge, priming: hold tap=0 through reset release, then at coarse=10 drive tap=16'h003F for one cycle and 16'hFFFF afterwards. Expect one event, coarse=10, fine=6, pol=1, out_valid high 4 clks later. The all-ones cycles produce no extra event.
- Bubble suppression: drive tap=16'h00BF (bit 6 missing). Expect fine=7. With tap=16'h0047, expect fine=3.
- Overflow and clear_ovf: with out_ready=0, generate 6 rising events. Expect 4 entries, overflow=1, drop_cnt=2. Pulse clear_ovf, then drain with out_ready=1. Expect 4 events in order and overflow=0.
- Boundary cases: at coarse=255 followed by an event at coarse=0, expect out_coarse 255 then 0. Assert RESET with tap=16'hFFFF and deassert it. Expect no event until tap returns to 0 and rises again.
- TDC_FALLING_EDGE_EN: after tap=16'hFFFF, drive tap=16'hFFF0. Expect fine=4, pol=0. Without the macro, the same stimulus produces no event.
